// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision field layout, constants and divider state encoding
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int EXP_BIAS  = 127;
  localparam int DIV_ITERS = 26;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, PRE, DIV, RND} state_t;

  function automatic logic [31:0] fp_inf(input logic s);
    return {s, EXP_MAX, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic [31:0] fp_zero(input logic s);
    return {s, 31'b0};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - zero/infinity/NaN classification of one operand (subnormals count as zero)
module fp_classify
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0]  exponent,
  input  logic [FRAC_W-1:0] fraction,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  assign is_zero = (exponent == '0);
  assign is_inf  = (exponent == EXP_MAX) && (fraction == '0);
  assign is_nan  = (exponent == EXP_MAX) && (fraction != '0);

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential single-precision divider, restoring radix-2, round-to-nearest-even
module div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] m,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        divzero
);

  state_t             state;
  logic [31:0]        a_r, b_r;
  logic [24:0]        rem;
  logic [23:0]        dvs;
  logic [25:0]        quo;
  logic signed [9:0]  e_r;
  logic [4:0]         cnt;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic sign;

  fp_classify u_cls_a (
    .exponent (a_r[30:23]),
    .fraction (a_r[22:0]),
    .is_zero  (a_zero),
    .is_inf   (a_inf),
    .is_nan   (a_nan)
  );

  fp_classify u_cls_b (
    .exponent (b_r[30:23]),
    .fraction (b_r[22:0]),
    .is_zero  (b_zero),
    .is_inf   (b_inf),
    .is_nan   (b_nan)
  );

  assign sign = a_r[31] ^ b_r[31];

  logic        sp_hit, sp_dz;
  logic [31:0] sp_val;
  logic signed [9:0] e_pre;

  always_comb begin
    sp_hit = 1'b1;
    sp_dz  = 1'b0;
    sp_val = QNAN;
    if (a_nan || b_nan)                         sp_val = QNAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) sp_val = QNAN;
    else if (a_inf)                             sp_val = fp_inf(sign);
    else if (b_inf || a_zero)                   sp_val = fp_zero(sign);
    else if (b_zero) begin
      sp_val = fp_inf(sign);
      sp_dz  = 1'b1;
    end else                                    sp_hit = 1'b0;
    e_pre = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'(EXP_BIAS);
  end

  // One restoring step: the remainder stays below 2*divisor, so 25 bits never overflow.
  logic        ge;
  logic [24:0] rem_sub, rem_next;

  always_comb begin
    ge       = (rem >= {1'b0, dvs});
    rem_sub  = ge ? (rem - {1'b0, dvs}) : rem;
    rem_next = {rem_sub[23:0], 1'b0};
  end

  logic              norm, guard, sticky, rnd_up;
  logic [23:0]       sig_pre;
  logic [24:0]       sig_sum;
  logic [22:0]       frac_fin;
  logic signed [9:0] e_norm, e_fin;

  // A round-up carry to 2^24 leaves zeros below, so shifting right by one renormalises it.
  always_comb begin
    norm     = quo[25];
    sig_pre  = norm ? quo[25:2] : quo[24:1];
    guard    = norm ? quo[1] : quo[0];
    sticky   = (norm & quo[0]) | (rem != '0);
    e_norm   = norm ? e_r : (e_r - 10'sd1);
    rnd_up   = guard & (sticky | sig_pre[0]);
    sig_sum  = {1'b0, sig_pre} + {24'b0, rnd_up};
    frac_fin = sig_sum[24] ? sig_sum[23:1] : sig_sum[22:0];
    e_fin    = sig_sum[24] ? (e_norm + 10'sd1) : e_norm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      e_r       <= '0;
      cnt       <= '0;
      m         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      divzero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r       <= a;
            b_r       <= b;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            divzero   <= 1'b0;
            state     <= PRE;
          end
        end
        PRE: begin
          if (sp_hit) begin
            m       <= sp_val;
            divzero <= sp_dz;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            rem   <= {2'b01, a_r[22:0]};
            dvs   <= {1'b1, b_r[22:0]};
            e_r   <= e_pre;
            quo   <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          quo <= {quo[24:0], ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITERS - 1)) state <= RND;
        end
        RND: begin
          if (e_fin >= 10'sd255) begin
            m        <= fp_inf(sign);
            overflow <= 1'b1;
          end else if (e_fin <= 10'sd0) begin
            m         <= fp_zero(sign);
            underflow <= 1'b1;
          end else begin
            m <= {sign, e_fin[7:0], frac_fin};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq against an integer-arithmetic reference model
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] m;
  logic        busy, done, overflow, underflow, divzero;

  always #5 clk = ~clk;

  div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .m         (m),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .underflow (underflow),
    .divzero   (divzero)
  );

  typedef struct {
    logic [31:0] m;
    logic        ov, un, dz;
    int          lat;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    int   done_at;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic res_t mk(input logic [31:0] mv, input bit ov, input bit un, input bit dz, input int lat);
    res_t r;
    r.m = mv; r.ov = ov; r.un = un; r.dz = dz; r.lat = lat;
    return r;
  endfunction

  // Reference: exact integer quotient with one extra bit for guard, remainder for sticky.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    int          ex, ey, e, sh;
    bit          s, xz, xi, xn, yz, yi, yn, guard, sticky;
    bit [63:0]   ma, mb, qq, rm, sig;
    logic [7:0]  e8;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);   xi = (ex == 255) && (x[22:0] == 0); xn = (ex == 255) && (x[22:0] != 0);
    yz = (ey == 0);   yi = (ey == 255) && (y[22:0] == 0); yn = (ey == 255) && (y[22:0] != 0);
    r = mk(32'h0, 0, 0, 0, 1);
    if (xn || yn)                    r.m = 32'h7FC00000;
    else if ((xz && yz) || (xi && yi)) r.m = 32'h7FC00000;
    else if (xi)                     r.m = {s, 8'hFF, 23'h0};
    else if (yi || xz)               r.m = {s, 31'h0};
    else if (yz) begin
      r.m  = {s, 8'hFF, 23'h0};
      r.dz = 1;
    end else begin
      r.lat = 28;
      ma = 64'h800000 | 64'(x[22:0]);
      mb = 64'h800000 | 64'(y[22:0]);
      e  = ex - ey + 127;
      if (ma >= mb) sh = 24;
      else begin
        sh = 25;
        e  = e - 1;
      end
      qq     = (ma << sh) / mb;
      rm     = (ma << sh) % mb;
      sig    = qq >> 1;
      guard  = qq[0];
      sticky = (rm != 0);
      if (guard && (sticky || sig[0])) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
        sig = 64'd1 << 23;
        e   = e + 1;
      end
      if (e >= 255) begin
        r.m  = {s, 8'hFF, 23'h0};
        r.ov = 1;
      end else if (e <= 0) begin
        r.m  = {s, 31'h0};
        r.un = 1;
      end else begin
        e8  = e[7:0];
        r.m = {s, e8, sig[22:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    f = 23'($urandom);
    k = $urandom_range(0, 15);
    if (k == 0)      e = 8'h00;
    else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = '0;
    end
    else if (k < 8)  e = 8'($urandom_range(100, 154));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   eb;
    if (mon_en && rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: actual m %h required no result", m);
        end else begin
          e = sb.pop_front();
          chk("m", m, e.r.m);
          chk("overflow", 32'(overflow), 32'(e.r.ov));
          chk("underflow", 32'(underflow), 32'(e.r.un));
          chk("divzero", 32'(divzero), 32'(e.r.dz));
          chk("done_cycle", 32'(cyc), 32'(e.done_at));
          chk("busy_at_done", 32'(busy), 32'(0));
        end
        last_m = m;
      end else begin
        eb = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].done_at);
        chk("busy", 32'(busy), 32'(eb));
        chk("m_hold", m, last_m);
      end
    end
  end

  task automatic issue_exp(input logic [31:0] xa, input logic [31:0] xb, input res_t r, input bit glitch);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: actual busy %0d required 0", busy);
      return;
    end
    a = xa;
    b = xb;
    start = 1'b1;
    e.r = r;
    e.acc = cyc + 1;
    e.done_at = cyc + 1 + r.lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    if (glitch && r.lat == 28) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      a = $urandom;
      b = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    chk("reset_m", m, 32'h0);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_overflow", 32'(overflow), 32'(0));
    chk("reset_underflow", 32'(underflow), 32'(0));
    chk("reset_divzero", 32'(divzero), 32'(0));
    rst_n = 1'b1;
    last_m = '0;
    mon_en = 1'b1;

    issue_exp(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 0);
    issue_exp(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 0, 0, 0, 28), 0);
    issue_exp(32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 0, 1, 1), 0);
    issue_exp(32'h00000000, 32'h00000000, mk(32'h7FC00000, 0, 0, 0, 1), 0);
    issue_exp(32'h7F800000, 32'h7F800000, mk(32'h7FC00000, 0, 0, 0, 1), 0);
    issue_exp(32'h7F000000, 32'h3E800000, mk(32'h7F800000, 1, 0, 0, 28), 0);
    issue_exp(32'h00800000, 32'h40000000, mk(32'h00000000, 0, 1, 0, 28), 0);
    issue_exp(32'hC0000000, 32'h3F800000, mk(32'hC0000000, 0, 0, 0, 28), 0);
    issue_exp(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 1);
    drain();

    issue_exp(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 0, 0, 0, 28), 0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'(0));
    chk("midreset_done", 32'(done), 32'(0));
    chk("midreset_m", m, 32'h0);
    chk("midreset_flags", {29'b0, overflow, underflow, divzero}, 32'h0);
    sb.delete();
    last_m = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue_exp(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0, 28), 0);

    for (int i = 0; i < 150; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      if ($urandom_range(0, 7) == 0) y[22:0] = x[22:0];
      issue_exp(x, y, model(x, y), ($urandom_range(0, 7) == 0));
    end
    drain();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential IEEE-754 single-precision divider, the inverse of the combinational multiplier in the floating-point unit: computes m = a / b with a restoring radix-2 mantissa divider, one quotient bit per clock. It sits beside the multiplier and shares its field layout, zero/infinity classification and overflow/underflow flag meaning. It adds a start/busy/done handshake, round-to-nearest-even, and defined results for every special case: no x outputs.

## Interface
- Parameters: none. Iteration count and bias are package constants.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; the only reset
- start  in  1  request; sampled only when busy=0
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- m  out  32  quotient; registered; held until next result
- busy  out  1  high from the accepting edge until the edge that raises done
- done  out  1  one-cycle pulse; m and flags valid while high and afterwards
- overflow  out  1  result exponent ≥ 255; m = signed infinity
- underflow  out  1  result exponent ≤ 0; m = signed zero (flush, no subnormals)
- divzero  out  1  finite non-zero a divided by zero

## Operation
- Reset: m=0, busy=0, done=0, all flags 0, state IDLE. Takes effect immediately, including mid-division. Any in-flight operation is discarded.
- States are IDLE, PRE, DIV, RND.
- IDLE: on start=1, latch a and b, set busy=1, go to PRE. When busy=1, start is ignored and has no effect on latched operands.
- PRE: classify each operand. Exponent 0 means zero (subnormals flushed). Exponent 255 with fraction 0 means infinity; exponent 255 with fraction ≠0 means NaN. Sign s = a[31]^b[31]. Special cases, first match wins:
  - either NaN → 32'h7FC00000
  - 0/0 or inf/inf → 32'h7FC00000
  - inf/x → {s,8'hFF,23'b0}
  - x/inf or 0/x → {s,31'b0}
  - x/0 → {s,8'hFF,23'b0} with divzero=1
- Special-case results are written directly, done=1, back to IDLE. Otherwise: R={1'b0,1,a[22:0]} (25 b), D={1,b[22:0]}, E = a_exp − b_exp + 127 as a signed 10-bit value, counter=0, go to DIV.
- DIV, 26 iterations: if R ≥ D, set q bit 1 and R ← R−D, else q bit 0; then R ← R<<1; q shifts in MSB first. q[25] has weight 2^0.
- RND, normalize:
  - q[25]=1: sig=q[25:2], guard=q[1], sticky=q[0]|(R≠0).
  - Otherwise: sig=q[24:1], guard=q[0], sticky=(R≠0), E←E−1.
- RND, round to nearest even: increment sig if guard & (sticky | sig[0]). If the increment carries out to 2^24, sig ← 2^23 and E←E+1.
- RND, range: E ≥ 255 → {s,8'hFF,0}, overflow=1. E ≤ 0 → {s,31'b0}, underflow=1. Else m={s,E[7:0],sig[22:0]}. Then done=1, go to IDLE.
- Flags are cleared at every accept and are valid together with done.

## Timing
- Edge 0 samples start. Normal operand: done=1 after edge 28, i.e. 28-cycle latency (PRE at edge 1, DIV at edges 2–27, RND at edge 28). Special case: done=1 after edge 1.
- busy falls on the same edge done rises. A start asserted during the done cycle is accepted, giving back-to-back throughput of one result per 29 cycles.
- done is high for exactly one cycle. m is stable from done until the next done.

## Structure
- Package fp_pkg holds:
  - EXP_BIAS=127, QNAN=32'h7FC00000, DIV_ITERS=26
  - field slice widths (EXP_W=8, FRAC_W=23)
  - the state enum {IDLE,PRE,DIV,RND}
- One sub-module, fp_classify: combinational, exp/frac in → is_zero, is_inf, is_nan. Instantiated twice, for a and b.

## Test plan
- 40C00000 / 40000000 (6/2) → m=40400000 after 28 cycles, all flags 0, busy high for cycles 0–27.
- 3F800000 / 40400000 (1/3) → m=3EAAAAAB (guard=1 rounds up).
- 3F800000 / 00000000 → m=7F800000, divzero=1, done after 1 cycle. 00000000/00000000 and 7F800000/7F800000 → 7FC00000.
- 7F000000 / 3E800000 → m=7F800000, overflow=1. 00800000 / 40000000 → m=00000000, underflow=1. C0000000 / 3F800000 → C0000000.
- Back-to-back: second start in the done cycle is accepted; start pulses at cycles 5 and 15 of an operation are ignored and the result is unchanged.
- Drop rst_n at cycle 10 of a division → busy=0, done=0, m=0 and flags 0 immediately. A fresh start after release completes normally.
